inst_fetch_queue: RTL and testbench

Instruction-fetch stage sitting directly downstream of the PC register. It consumes the PC register's pc/chip-enable output, issues in-order requests to instruction memory, and collects returned words into a DEPTH-entry ordered queue. It presents {pc, inst} pairs to decode over a valid/ready handshake. It back-pressures the PC register via fetch_stall and discards all in-flight work on flush (branch/jump redirect).

---
 rtl/inst_fetch_queue_pkg.sv | 24 ++
 rtl/inst_fetch_queue_if.sv | 43 ++++
 rtl/inst_fetch_queue_mem.sv | 60 ++++++
 rtl/inst_fetch_queue.sv | 113 +++++++++++
 tb/tb_inst_fetch_queue.sv | 367 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue_pkg
// Shared constants for the instruction-fetch queue slice: default address and
// instruction widths (matching the PC register), enable/disable levels, the
// zero instruction word and a helper that sizes occupancy counters.
// No ports.
// -----------------------------------------------------------------------------
package inst_fetch_queue_pkg;

  localparam int INST_ADDR_WIDTH = 32;
  localparam int INST_WIDTH      = 32;
  localparam int DEFAULT_DEPTH   = 4;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [INST_WIDTH-1:0] ZERO_WORD = {INST_WIDTH{1'b0}};

  // Counter width able to hold the values 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue_if
// Bundles the fetch stage's external signals:
//   PC side     : pc, pc_ce, fetch_stall, flush
//   memory side : imem_req, imem_addr, imem_rvalid, imem_rdata
//   decode side : id_valid, id_pc, id_inst, id_ready, id_count
// modport master : the fetch queue itself
// modport slave  : the environment (PC register, instruction memory, decode)
// -----------------------------------------------------------------------------
interface inst_fetch_queue_if
  import inst_fetch_queue_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_WIDTH,
  parameter int INST_W = INST_WIDTH,
  parameter int DEPTH  = DEFAULT_DEPTH
);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [ADDR_W-1:0] pc;
  logic              pc_ce;
  logic              fetch_stall;
  logic              flush;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rvalid;
  logic [INST_W-1:0] imem_rdata;
  logic              id_valid;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;
  logic              id_ready;
  logic [CNT_W-1:0]  id_count;

  modport master (
    input  pc, pc_ce, flush, imem_rvalid, imem_rdata, id_ready,
    output fetch_stall, imem_req, imem_addr, id_valid, id_pc, id_inst, id_count
  );

  modport slave (
    output pc, pc_ce, flush, imem_rvalid, imem_rdata, id_ready,
    input  fetch_stall, imem_req, imem_addr, id_valid, id_pc, id_inst, id_count
  );

endinterface

// File: rtl/inst_fetch_queue_mem.sv
// -----------------------------------------------------------------------------
// fetch_queue_mem
// DEPTH-entry register file of {pc, inst, filled}.
//   clk, rst                           : clock, synchronous active-high reset
//   i_alloc_en/i_alloc_idx/i_alloc_pc  : allocate write (stores pc, clears filled)
//   i_fill_en/i_fill_idx/i_fill_inst   : fill write (stores inst, sets filled)
//   i_head_idx                         : asynchronous read index
//   o_head_pc/o_head_inst/o_head_filled: contents of the indexed entry
// -----------------------------------------------------------------------------
module fetch_queue_mem
  import inst_fetch_queue_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_WIDTH,
  parameter int INST_W = INST_WIDTH,
  parameter int DEPTH  = DEFAULT_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_alloc_en,
  input  logic [PTR_W-1:0]  i_alloc_idx,
  input  logic [ADDR_W-1:0] i_alloc_pc,
  input  logic              i_fill_en,
  input  logic [PTR_W-1:0]  i_fill_idx,
  input  logic [INST_W-1:0] i_fill_inst,
  input  logic [PTR_W-1:0]  i_head_idx,
  output logic [ADDR_W-1:0] o_head_pc,
  output logic [INST_W-1:0] o_head_inst,
  output logic              o_head_filled
);

  logic [ADDR_W-1:0] r_pc     [DEPTH];
  logic [INST_W-1:0] r_inst   [DEPTH];
  logic              r_filled [DEPTH];

  // Entry storage: the allocate and fill ports never target the same entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]     <= {ADDR_W{1'b0}};
        r_inst[i]   <= INST_W'(ZERO_WORD);
        r_filled[i] <= DISABLE;
      end
    end else begin
      if (i_alloc_en) begin
        r_pc[i_alloc_idx]     <= i_alloc_pc;
        r_filled[i_alloc_idx] <= DISABLE;
      end
      if (i_fill_en) begin
        r_inst[i_fill_idx]   <= i_fill_inst;
        r_filled[i_fill_idx] <= ENABLE;
      end
    end
  end

  assign o_head_pc     = r_pc[i_head_idx];
  assign o_head_inst   = r_inst[i_head_idx];
  assign o_head_filled = r_filled[i_head_idx];

endmodule

// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
// Fetch stage between the PC register and decode. Issues in-order instruction
// memory reads for each accepted pc, collects the returned words into an
// ordered DEPTH-entry queue and hands {pc, inst} to decode over valid/ready.
// flush discards queued entries and silently drops responses still in flight.
//   clk, rst : clock, synchronous active-high reset
//   bus      : inst_fetch_queue_if.master (PC, memory and decode signals)
// -----------------------------------------------------------------------------
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_WIDTH,
  parameter int INST_W = INST_WIDTH,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input logic                clk,
  input logic                rst,
  inst_fetch_queue_if.master bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);
  localparam int OCC_W = CNT_W + 1;

  logic [PTR_W-1:0]  r_alloc_ptr;
  logic [PTR_W-1:0]  r_fill_ptr;
  logic [PTR_W-1:0]  r_head_ptr;
  logic [CNT_W-1:0]  r_count;     // allocated entries
  logic [CNT_W-1:0]  r_pend;      // allocated entries still waiting for data
  logic [CNT_W-1:0]  r_drop_cnt;  // responses owed to flushed requests

  logic [OCC_W-1:0]  w_occupancy;
  logic              w_stall;
  logic              w_issue;
  logic              w_fill;
  logic              w_pop;
  logic              w_valid;
  logic              w_rsp_taken;
  logic              w_head_filled;
  logic [ADDR_W-1:0] w_head_pc;
  logic [INST_W-1:0] w_head_inst;

  // Flushed-but-outstanding requests still occupy memory credits.
  assign w_occupancy = {1'b0, r_count} + {1'b0, r_drop_cnt};
  assign w_stall     = (w_occupancy >= OCC_W'(DEPTH));
  assign w_issue     = bus.pc_ce & ~w_stall & ~bus.flush & ~rst;
  assign w_fill      = bus.imem_rvalid & (r_drop_cnt == CNT_W'(0)) & (r_pend != CNT_W'(0));
  assign w_valid     = w_head_filled & (r_count != CNT_W'(0));
  assign w_pop       = w_valid & bus.id_ready;
  // A response that belongs to some outstanding request (dropped or not).
  assign w_rsp_taken = bus.imem_rvalid & ((r_drop_cnt != CNT_W'(0)) | (r_pend != CNT_W'(0)));

  fetch_queue_mem #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk           (clk),
    .rst           (rst),
    .i_alloc_en    (w_issue),
    .i_alloc_idx   (r_alloc_ptr),
    .i_alloc_pc    (bus.pc),
    .i_fill_en     (w_fill & ~bus.flush),
    .i_fill_idx    (r_fill_ptr),
    .i_fill_inst   (bus.imem_rdata),
    .i_head_idx    (r_head_ptr),
    .o_head_pc     (w_head_pc),
    .o_head_inst   (w_head_inst),
    .o_head_filled (w_head_filled)
  );

  // Pointer, occupancy and drop bookkeeping; flush overrides all other activity.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alloc_ptr <= {PTR_W{1'b0}};
      r_fill_ptr  <= {PTR_W{1'b0}};
      r_head_ptr  <= {PTR_W{1'b0}};
      r_count     <= {CNT_W{1'b0}};
      r_pend      <= {CNT_W{1'b0}};
      r_drop_cnt  <= {CNT_W{1'b0}};
    end else if (bus.flush) begin
      r_alloc_ptr <= {PTR_W{1'b0}};
      r_fill_ptr  <= {PTR_W{1'b0}};
      r_head_ptr  <= {PTR_W{1'b0}};
      r_count     <= {CNT_W{1'b0}};
      r_pend      <= {CNT_W{1'b0}};
      // Every unfilled entry leaves a response in flight; one arriving now is
      // already accounted for.
      r_drop_cnt  <= r_drop_cnt + r_pend - CNT_W'(w_rsp_taken);
    end else begin
      r_alloc_ptr <= r_alloc_ptr + PTR_W'(w_issue);
      r_fill_ptr  <= r_fill_ptr + PTR_W'(w_fill);
      r_head_ptr  <= r_head_ptr + PTR_W'(w_pop);
      r_count     <= r_count + CNT_W'(w_issue) - CNT_W'(w_pop);
      r_pend      <= r_pend + CNT_W'(w_issue) - CNT_W'(w_fill);
      if (bus.imem_rvalid && (r_drop_cnt != CNT_W'(0))) begin
        r_drop_cnt <= r_drop_cnt - CNT_W'(1);
      end else begin
        r_drop_cnt <= r_drop_cnt;
      end
    end
  end

  assign bus.fetch_stall = w_stall;
  assign bus.imem_req    = w_issue;
  assign bus.imem_addr   = bus.pc;
  assign bus.id_valid    = w_valid;
  assign bus.id_pc       = w_head_pc;
  assign bus.id_inst     = w_head_inst;
  assign bus.id_count    = r_count;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_queue
// Self-checking bench for inst_fetch_queue. A behavioural model keeps the
// expected queue as a list of {pc, inst, filled} records and the instruction
// memory as a list of pending responses tagged with a flush epoch; responses
// from an older epoch are the ones the fetch stage must throw away.
// -----------------------------------------------------------------------------
module tb_inst_fetch_queue;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    bit                filled;
  } ent_t;

  typedef struct {
    logic [INST_W-1:0] data;
    int                epoch;
    int                due;
  } rsp_t;

  logic clk;
  logic rst;

  inst_fetch_queue_if #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH)) bus ();

  inst_fetch_queue #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;
  int cyc;
  int epoch;
  int last_due;
  int serial;
  int pops;
  int first_pop_cyc;
  int lat;
  bit chk_en;

  bit rst_s, pc_ce_s, flush_s, ready_s, stray_s;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] flush_pc;
  logic [ADDR_W-1:0] last_pop_pc;

  ent_t mq[$];
  rsp_t mem_q[$];

  function automatic logic [INST_W-1:0] mk_data(input logic [ADDR_W-1:0] a, input int s);
    logic [31:0] s32;
    s32 = 32'(s);
    return (a * 32'h9E37_79B1) ^ (s32 * 32'h0101_0101) ^ 32'h5A5A_0F0F;
  endfunction

  // One clock cycle: drive inputs, compare outputs against the model on the
  // falling edge, then advance the model by the rules of the fetch stage.
  task automatic step();
    bit rsp, exp_stall, exp_req, exp_valid, found;
    int old_n, due;
    rsp_t m;
    ent_t e;
    rsp = !rst_s && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    rst = rst_s;
    bus.pc = pc_reg;
    bus.pc_ce = pc_ce_s;
    bus.flush = flush_s;
    bus.id_ready = ready_s;
    bus.imem_rvalid = rsp | stray_s;
    bus.imem_rdata = rsp ? mem_q[0].data : 32'hDEAD_BEEF;
    @(negedge clk);
    old_n = 0;
    foreach (mem_q[i]) if (mem_q[i].epoch != epoch) old_n++;
    exp_stall = (mq.size() + old_n) >= DEPTH;
    exp_req   = pc_ce_s && !exp_stall && !flush_s && !rst_s;
    exp_valid = (mq.size() > 0) && mq[0].filled;
    if (chk_en) begin
      checks++;
      if (bus.fetch_stall !== exp_stall) begin
        failures++; $display("FAIL fetch_stall cyc=%0d got=%b exp=%b", cyc, bus.fetch_stall, exp_stall);
      end
      checks++;
      if (bus.imem_req !== exp_req) begin
        failures++; $display("FAIL imem_req cyc=%0d got=%b exp=%b", cyc, bus.imem_req, exp_req);
      end
      checks++;
      if (bus.imem_addr !== pc_reg) begin
        failures++; $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, bus.imem_addr, pc_reg);
      end
      checks++;
      if (bus.id_valid !== exp_valid) begin
        failures++; $display("FAIL id_valid cyc=%0d got=%b exp=%b", cyc, bus.id_valid, exp_valid);
      end
      checks++;
      if (bus.id_count !== CNT_W'(mq.size())) begin
        failures++; $display("FAIL id_count cyc=%0d got=%0d exp=%0d", cyc, bus.id_count, mq.size());
      end
      if (exp_valid) begin
        checks++;
        if (bus.id_pc !== mq[0].pc || bus.id_inst !== mq[0].inst) begin
          failures++;
          $display("FAIL id_entry cyc=%0d got=%h/%h exp=%h/%h", cyc, bus.id_pc, bus.id_inst, mq[0].pc, mq[0].inst);
        end
      end
    end
    if (rst_s) begin
      mq.delete(); mem_q.delete(); epoch++; last_due = 0;
    end else begin
      if (rsp) begin
        m = mem_q.pop_front();
        if (!flush_s && m.epoch == epoch) begin
          found = 1'b0;
          for (int i = 0; i < mq.size(); i++) begin
            if (!found && !mq[i].filled) begin
              mq[i].inst = m.data; mq[i].filled = 1'b1; found = 1'b1;
            end
          end
          if (!found) begin
            failures++; $display("FAIL model_fill cyc=%0d got=no_entry exp=unfilled_entry", cyc);
          end
        end
      end
      if (exp_valid && ready_s && !flush_s) begin
        last_pop_pc = mq[0].pc; pops++;
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
        mq.delete(0);
      end
      if (exp_req) begin
        e.pc = pc_reg; e.inst = '0; e.filled = 1'b0; mq.push_back(e);
        due = cyc + lat; if (due <= last_due) due = last_due + 1; last_due = due;
        m.data = mk_data(pc_reg, serial); m.epoch = epoch; m.due = due; serial++;
        mem_q.push_back(m);
      end
      if (flush_s) begin
        mq.delete(); epoch++; pc_reg = flush_pc;
      end else if (exp_req) begin
        pc_reg = pc_reg + 32'd4;
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_s = 1'b1; pc_ce_s = 1'b0; flush_s = 1'b0; stray_s = 1'b0; ready_s = 1'b0;
    step();
    rst_s = 1'b0; lat = 1; pc_reg = 32'h0;
  endtask

  task automatic test_reset();
    rst_s = 1'b1; pc_ce_s = 1'b1; pc_reg = 32'h0; lat = 1;
    step(); step();
    checks++;
    if (bus.imem_req !== 1'b0) begin
      failures++; $display("FAIL reset_req got=%b exp=0", bus.imem_req);
    end
    rst_s = 1'b0; pc_ce_s = 1'b0;
    checks++;
    if (bus.id_valid !== 1'b0 || bus.id_count !== CNT_W'(0) || bus.fetch_stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got=%b/%0d/%b exp=0/0/0", bus.id_valid, bus.id_count, bus.fetch_stall);
    end
  endtask

  task automatic test_stream();
    int p0, c0;
    do_reset();
    ready_s = 1'b1; pc_ce_s = 1'b1; p0 = pops; c0 = cyc; first_pop_cyc = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (bus.fetch_stall !== 1'b0) begin
        failures++; $display("FAIL stream_stall i=%0d got=%b exp=0", i, bus.fetch_stall);
      end
    end
    pc_ce_s = 1'b0;
    step(); step();
    checks++;
    if (pops - p0 != 20) begin
      failures++; $display("FAIL stream_pops got=%0d exp=20", pops - p0);
    end
    checks++;
    if (first_pop_cyc - c0 != 2) begin
      failures++; $display("FAIL stream_latency got=%0d exp=2", first_pop_cyc - c0);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ready_s = 1'b0; pc_ce_s = 1'b1;
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (bus.id_count !== CNT_W'(4) || bus.fetch_stall !== 1'b1 || bus.imem_req !== 1'b0) begin
      failures++;
      $display("FAIL bp_full got=%0d/%b/%b exp=4/1/0", bus.id_count, bus.fetch_stall, bus.imem_req);
    end
    checks++;
    if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h0) begin
      failures++; $display("FAIL bp_head got=%b/%h exp=1/00000000", bus.id_valid, bus.id_pc);
    end
    ready_s = 1'b1;
    step();
    checks++;
    if (bus.id_count !== CNT_W'(3) || bus.fetch_stall !== 1'b0 || bus.id_pc !== 32'h4) begin
      failures++;
      $display("FAIL bp_pop got=%0d/%b/%h exp=3/0/00000004", bus.id_count, bus.fetch_stall, bus.id_pc);
    end
    step();
    checks++;
    if (bus.id_count !== CNT_W'(3)) begin
      failures++; $display("FAIL bp_resume got=%0d exp=3", bus.id_count);
    end
    pc_ce_s = 1'b0;
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (bus.id_count !== CNT_W'(0)) begin
      failures++; $display("FAIL bp_drain got=%0d exp=0", bus.id_count);
    end
  endtask

  task automatic test_flush();
    int p0;
    do_reset();
    lat = 3; ready_s = 1'b1; pc_reg = 32'h10; pc_ce_s = 1'b1;
    step(); step(); step();
    pc_ce_s = 1'b0; flush_s = 1'b1; flush_pc = 32'h100;
    step();
    flush_s = 1'b0;
    checks++;
    if (bus.id_valid !== 1'b0 || bus.id_count !== CNT_W'(0)) begin
      failures++; $display("FAIL flush_clear got=%b/%0d exp=0/0", bus.id_valid, bus.id_count);
    end
    p0 = pops; pc_ce_s = 1'b1;
    step();
    pc_ce_s = 1'b0;
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (pops - p0 != 1 || last_pop_pc !== 32'h100) begin
      failures++; $display("FAIL flush_redirect got=%0d/%h exp=1/00000100", pops - p0, last_pop_pc);
    end
  endtask

  task automatic test_wrap();
    int p0;
    do_reset();
    ready_s = 1'b1; pc_reg = 32'h40; pc_ce_s = 1'b1; p0 = pops;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i >= 1) begin
        checks++;
        if (bus.id_count !== CNT_W'(2)) begin
          failures++; $display("FAIL wrap_count i=%0d got=%0d exp=2", i, bus.id_count);
        end
      end
    end
    pc_ce_s = 1'b0;
    step(); step(); step();
    checks++;
    if (pops - p0 != 10 || bus.id_count !== CNT_W'(0)) begin
      failures++; $display("FAIL wrap_drain got=%0d/%0d exp=10/0", pops - p0, bus.id_count);
    end
  endtask

  task automatic test_stray();
    int p0;
    do_reset();
    stray_s = 1'b1;
    step(); step(); step();
    stray_s = 1'b0;
    checks++;
    if (bus.id_valid !== 1'b0 || bus.id_count !== CNT_W'(0)) begin
      failures++; $display("FAIL stray_state got=%b/%0d exp=0/0", bus.id_valid, bus.id_count);
    end
    p0 = pops; pc_reg = 32'h200; pc_ce_s = 1'b1; ready_s = 1'b1;
    step();
    pc_ce_s = 1'b0;
    step(); step(); step();
    checks++;
    if (pops - p0 != 1 || last_pop_pc !== 32'h200) begin
      failures++; $display("FAIL stray_after got=%0d/%h exp=1/00000200", pops - p0, last_pop_pc);
    end
  endtask

  task automatic test_reset_mid();
    int p0;
    do_reset();
    lat = 2; ready_s = 1'b0; pc_ce_s = 1'b1;
    step(); step(); step();
    pc_ce_s = 1'b0;
    step();
    rst_s = 1'b1;
    step();
    rst_s = 1'b0;
    checks++;
    if (bus.id_valid !== 1'b0 || bus.id_count !== CNT_W'(0) || bus.fetch_stall !== 1'b0) begin
      failures++;
      $display("FAIL midreset_state got=%b/%0d/%b exp=0/0/0", bus.id_valid, bus.id_count, bus.fetch_stall);
    end
    p0 = pops; pc_reg = 32'h0; pc_ce_s = 1'b1; ready_s = 1'b1;
    step();
    pc_ce_s = 1'b0;
    step(); step(); step();
    checks++;
    if (pops - p0 != 1 || last_pop_pc !== 32'h0) begin
      failures++; $display("FAIL midreset_fetch got=%0d/%h exp=1/00000000", pops - p0, last_pop_pc);
    end
  endtask

  task automatic test_random();
    int p0;
    do_reset();
    p0 = pops;
    for (int i = 0; i < 800; i++) begin
      pc_ce_s  = ($urandom % 4) != 0;
      ready_s  = ($urandom % 3) != 0;
      flush_s  = ($urandom % 20) == 0;
      flush_pc = 32'($urandom_range(0, 4095)) << 2;
      lat      = 1 + int'($urandom % 4);
      stray_s  = (mem_q.size() == 0) && (($urandom % 6) == 0);
      rst_s    = ($urandom % 200) == 0;
      step();
    end
    pc_ce_s = 1'b0; flush_s = 1'b0; stray_s = 1'b0; rst_s = 1'b0; ready_s = 1'b1;
    for (int i = 0; i < 12; i++) step();
    checks++;
    if (pops - p0 <= 0) begin
      failures++; $display("FAIL random_progress got=%0d exp=>0", pops - p0);
    end
    checks++;
    if (bus.id_count !== CNT_W'(0)) begin
      failures++; $display("FAIL random_drain got=%0d exp=0", bus.id_count);
    end
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; epoch = 0; last_due = 0; serial = 0;
    pops = 0; first_pop_cyc = -1; lat = 1; chk_en = 1'b0;
    rst_s = 1'b1; pc_ce_s = 1'b0; flush_s = 1'b0; ready_s = 1'b0; stray_s = 1'b0;
    pc_reg = 32'h0; flush_pc = 32'h0; last_pop_pc = 32'h0;
    rst = 1'b1;
    bus.pc = 32'h0; bus.pc_ce = 1'b0; bus.flush = 1'b0; bus.id_ready = 1'b0;
    bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_wrap();
    test_stray();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
